// File: rtl/ls_dma_ctrl_pkg.sv
// rtl/ls_dma_ctrl_pkg.sv - shared types, state encodings and helpers for the LocalStore DMA controller
package ls_dma_ctrl_pkg;

  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned DATA_W    = 128;
  localparam int unsigned LEN_W     = 8;
  localparam int unsigned QW_STRIDE = 16;

  typedef logic [0:ADDR_W-1] ls_addr_t;
  typedef logic [0:DATA_W-1] qword_t;
  typedef logic [0:LEN_W-1]  qw_len_t;

  typedef enum logic [1:0] {
    LSD_IDLE  = 2'd0,
    LSD_XFER  = 2'd1,
    LSD_DRAIN = 2'd2,
    LSD_DONE  = 2'd3
  } lsd_state_t;

  typedef enum logic {
    DIR_PUT = 1'b0,
    DIR_GET = 1'b1
  } dma_dir_t;

  // DMA transfers are quadword granular: the byte-within-quadword bits are dropped
  function automatic ls_addr_t qw_align(input ls_addr_t a);
    ls_addr_t r;
    r = a;
    r[11:14] = 4'b0000;
    return r;
  endfunction

endpackage

// File: rtl/ls_dma_ctrl_if.sv
// rtl/ls_dma_ctrl_if.sv - odd-pipe, LocalStore, DMA command and stream signals of the controller
interface ls_dma_ctrl_if;
  import ls_dma_ctrl_pkg::*;

  logic     pipe_req;
  logic     pipe_we;
  ls_addr_t pipe_addr;
  qword_t   pipe_wdata;
  logic     pipe_stall;

  logic     ls_en;
  logic     ls_we;
  ls_addr_t ls_addr;
  qword_t   ls_wdata;
  qword_t   ls_rdata;

  logic     cmd_valid;
  logic     cmd_ready;
  ls_addr_t cmd_addr;
  qw_len_t  cmd_len;
  logic     cmd_dir;

  logic     in_valid;
  logic     in_ready;
  qword_t   in_data;

  logic     out_valid;
  logic     out_ready;
  qword_t   out_data;

  logic     dma_abort;
  logic     dma_busy;
  logic     dma_done;
  logic     dma_aborted;

  modport slave (
    input  pipe_req, pipe_we, pipe_addr, pipe_wdata, ls_rdata,
    input  cmd_valid, cmd_addr, cmd_len, cmd_dir,
    input  in_valid, in_data, out_ready, dma_abort,
    output pipe_stall, ls_en, ls_we, ls_addr, ls_wdata,
    output cmd_ready, in_ready, out_valid, out_data,
    output dma_busy, dma_done, dma_aborted
  );

  modport master (
    output pipe_req, pipe_we, pipe_addr, pipe_wdata, ls_rdata,
    output cmd_valid, cmd_addr, cmd_len, cmd_dir,
    output in_valid, in_data, out_ready, dma_abort,
    input  pipe_stall, ls_en, ls_we, ls_addr, ls_wdata,
    input  cmd_ready, in_ready, out_valid, out_data,
    input  dma_busy, dma_done, dma_aborted
  );

endinterface

// File: rtl/ls_port_arbiter.sv
// rtl/ls_port_arbiter.sv - two-way LocalStore port mux, odd pipe first, starvation counter for the DMA
module ls_port_arbiter
  import ls_dma_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     pipe_req,
  input  logic     pipe_we,
  input  ls_addr_t pipe_addr,
  input  qword_t   pipe_wdata,
  input  logic     dma_req,
  input  logic     dma_we,
  input  ls_addr_t dma_addr,
  input  qword_t   dma_wdata,
  output logic     dma_grant,
  output logic     pipe_stall,
  output logic     ls_en,
  output logic     ls_we,
  output ls_addr_t ls_addr,
  output qword_t   ls_wdata
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] starve_cnt;
  logic             starved;

  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Grant decision and port mux; an idle port drives zeros rather than stale pipe values
  always_comb begin
    dma_grant  = dma_req && (!pipe_req || starved);
    pipe_stall = dma_req && pipe_req && starved;
    ls_en      = 1'b0;
    ls_we      = 1'b0;
    ls_addr    = '0;
    ls_wdata   = '0;
    if (dma_grant) begin
      ls_en    = 1'b1;
      ls_we    = dma_we;
      ls_addr  = dma_addr;
      ls_wdata = dma_wdata;
    end else if (pipe_req) begin
      ls_en    = 1'b1;
      ls_we    = pipe_we;
      ls_addr  = pipe_addr;
      ls_wdata = pipe_wdata;
    end
  end

  // Count cycles the DMA asked and lost; any DMA grant restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
    end else if (dma_grant) begin
      starve_cnt <= '0;
    end else if (dma_req && pipe_req) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/ls_dma_ctrl.sv
// rtl/ls_dma_ctrl.sv - LocalStore access controller sharing the port between odd pipe and quadword DMA
module ls_dma_ctrl
  import ls_dma_ctrl_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 8
) (
  input logic          clk,
  input logic          rst,
  ls_dma_ctrl_if.slave bus
);

  lsd_state_t state;
  ls_addr_t   addr;
  qw_len_t    remaining;
  dma_dir_t   dir;
  logic       out_valid;
  qword_t     out_data;
  logic       cmd_ready;
  logic       busy;
  logic       done;
  logic       aborted;

  logic       dma_req;
  logic       dma_grant;
  logic       pipe_stall;
  logic       ls_en;
  logic       ls_we;
  ls_addr_t   ls_addr;
  qword_t     ls_wdata;

  // DMA wants the port in XFER when it has data to write or room to catch a read; abort suppresses the beat
  always_comb begin
    dma_req = 1'b0;
    if (state == LSD_XFER && !bus.dma_abort) begin
      if (dir == DIR_PUT) begin
        dma_req = bus.in_valid;
      end else begin
        dma_req = !out_valid || bus.out_ready;
      end
    end
  end

  ls_port_arbiter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_arb (
    .clk        (clk),
    .rst        (rst),
    .pipe_req   (bus.pipe_req),
    .pipe_we    (bus.pipe_we),
    .pipe_addr  (bus.pipe_addr),
    .pipe_wdata (bus.pipe_wdata),
    .dma_req    (dma_req),
    .dma_we     (dir == DIR_PUT),
    .dma_addr   (addr),
    .dma_wdata  (bus.in_data),
    .dma_grant  (dma_grant),
    .pipe_stall (pipe_stall),
    .ls_en      (ls_en),
    .ls_we      (ls_we),
    .ls_addr    (ls_addr),
    .ls_wdata   (ls_wdata)
  );

  assign bus.pipe_stall  = pipe_stall;
  assign bus.ls_en       = ls_en;
  assign bus.ls_we       = ls_we;
  assign bus.ls_addr     = ls_addr;
  assign bus.ls_wdata    = ls_wdata;
  assign bus.in_ready    = dma_grant && (dir == DIR_PUT);
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = out_data;
  assign bus.cmd_ready   = cmd_ready;
  assign bus.dma_busy    = busy;
  assign bus.dma_done    = done;
  assign bus.dma_aborted = aborted;

  // Transfer FSM with address/count registers, get output register and registered status outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LSD_IDLE;
      addr      <= '0;
      remaining <= '0;
      dir       <= DIR_PUT;
      out_valid <= 1'b0;
      out_data  <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
      aborted   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        LSD_IDLE: begin
          if (bus.cmd_valid) begin
            addr      <= qw_align(bus.cmd_addr);
            remaining <= bus.cmd_len;
            dir       <= dma_dir_t'(bus.cmd_dir);
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            if (bus.cmd_len == '0) begin
              state <= LSD_DONE;
              done  <= 1'b1;
            end else begin
              state <= LSD_XFER;
            end
          end
        end
        LSD_XFER: begin
          if (bus.dma_abort) begin
            state     <= LSD_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            aborted   <= 1'b1;
          end else begin
            if (out_valid && bus.out_ready) begin
              out_valid <= 1'b0;
            end
            if (dma_grant) begin
              addr      <= addr + ls_addr_t'(QW_STRIDE);
              remaining <= remaining - qw_len_t'(1);
              if (dir == DIR_GET) begin
                out_data  <= bus.ls_rdata;
                out_valid <= 1'b1;
              end
              if (remaining == qw_len_t'(1)) begin
                if (dir == DIR_GET) begin
                  state <= LSD_DRAIN;
                end else begin
                  state <= LSD_DONE;
                  done  <= 1'b1;
                end
              end
            end
          end
        end
        LSD_DRAIN: begin
          if (bus.dma_abort) begin
            state     <= LSD_IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            aborted   <= 1'b1;
          end else if (!out_valid || bus.out_ready) begin
            out_valid <= 1'b0;
            state     <= LSD_DONE;
            done      <= 1'b1;
          end
        end
        LSD_DONE: begin
          state     <= LSD_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
        default: begin
          state     <= LSD_IDLE;
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule
